agc_sequencer: RTL and testbench

- Per-channel controller that sequences one AGC core (rescale DSPs plus square/probit accumulators).
- Generates the measurement-period tick and clock enable, and defers the LFSR resync to a period boundary.
- Stages scale/offset loads and schedules the apply strobe to land on a period boundary.
- Captures accumulator results into holding registers with a valid/ack handshake toward the servo/register logic.

---
 rtl/agc_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_agc_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_sequencer.sv
// -----------------------------------------------------------------------------
// agc_sequencer
//
// Per-channel controller for one AGC core. It produces the measurement-period
// tick and accumulator clock enable, defers LFSR resync requests to the start
// of a period, stages scale/offset loads and lines the apply strobe up with a
// period boundary. It also captures the accumulator results into holding
// registers behind a valid/ack handshake.
//
// Period timeline (one period = 2^PERIOD_BITS + CAPTURE_DELAY + 3 clocks):
//   PRE (1) -> TICK (1) -> RUN (2^PERIOD_BITS) -> DRAIN (CAPTURE_DELAY)
//   -> CAPTURE (1) -> PRE again while enable_i is high, otherwise IDLE.
//
// Optional build macro: AGC_PERIOD_COUNT_EN adds period_count_o, a 16-bit
// count of captures. It is cleared by reset and by a serviced resync.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   enable_i              run periods back-to-back while high
//   resync_i              pulse, request LFSR resync at the next PRE
//   scale_i/scale_wr_i    stage a new gain scale (strobed out next clock)
//   offset_i/offset_wr_i  stage a new offset (strobed out next clock)
//   apply_req_i           pulse, request an apply strobe
//   sq/gt/lt_accum_i      accumulator values from the core
//   agc_tick_o            period start, resets the accumulators
//   agc_ce_o              accumulator enable
//   agc_rst_o             LFSR reset
//   agc_scale_o/_ce_o     staged scale and its load strobe
//   agc_offset_o/_ce_o    staged offset and its load strobe
//   agc_apply_o           apply strobe
//   sq_o/gt_o/lt_o        captured results
//   valid_o/ack_i         results-held flag and its consumer acknowledge
//   overrun_o             sticky, a capture overwrote unacknowledged results
//   busy_o                sequencer is not idle
//   period_count_o        (AGC_PERIOD_COUNT_EN only) capture counter
// -----------------------------------------------------------------------------
module agc_sequencer #(
  parameter int PERIOD_BITS   = 17,
  parameter int CAPTURE_DELAY = 3,
  parameter int SQ_BITS       = 25,
  parameter int PR_BITS       = 21
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               enable_i,
  input  logic               resync_i,
  input  logic [16:0]        scale_i,
  input  logic               scale_wr_i,
  input  logic [15:0]        offset_i,
  input  logic               offset_wr_i,
  input  logic               apply_req_i,
  input  logic [SQ_BITS-1:0] sq_accum_i,
  input  logic [PR_BITS-1:0] gt_accum_i,
  input  logic [PR_BITS-1:0] lt_accum_i,
  output logic               agc_tick_o,
  output logic               agc_ce_o,
  output logic               agc_rst_o,
  output logic [16:0]        agc_scale_o,
  output logic               agc_scale_ce_o,
  output logic [15:0]        agc_offset_o,
  output logic               agc_offset_ce_o,
  output logic               agc_apply_o,
  output logic [SQ_BITS-1:0] sq_o,
  output logic [PR_BITS-1:0] gt_o,
  output logic [PR_BITS-1:0] lt_o,
  output logic               valid_o,
  input  logic               ack_i,
  output logic               overrun_o,
`ifdef AGC_PERIOD_COUNT_EN
  output logic [15:0]        period_count_o,
`endif
  output logic               busy_o
);

  localparam int DRAIN_W = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam logic [PERIOD_BITS-1:0] RUN_LAST   = {PERIOD_BITS{1'b1}};
  localparam logic [PERIOD_BITS-1:0] RUN_ZERO   = {PERIOD_BITS{1'b0}};
  localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(CAPTURE_DELAY - 1);
  localparam logic [DRAIN_W-1:0]     DRAIN_ZERO = {DRAIN_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_TICK    = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4,
    S_CAPTURE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [PERIOD_BITS-1:0] run_cnt_q, run_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;

  logic                 resync_pend_q, resync_pend_d;
  logic                 apply_pend_q, apply_pend_d;
  logic                 idle_apply_q, idle_apply_d;

  logic                 tick_q, tick_d;
  logic                 ce_q, ce_d;
  logic                 rst_q, rst_d;
  logic                 apply_q, apply_d;
  logic                 busy_q, busy_d;

  logic [16:0]          scale_q, scale_d;
  logic                 scale_ce_q, scale_ce_d;
  logic [15:0]          offset_q, offset_d;
  logic                 offset_ce_q, offset_ce_d;

  logic [SQ_BITS-1:0]   sq_q, sq_d;
  logic [PR_BITS-1:0]   gt_q, gt_d;
  logic [PR_BITS-1:0]   lt_q, lt_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic                 capture_s;

`ifdef AGC_PERIOD_COUNT_EN
  logic [15:0]          pcount_q, pcount_d;
`endif

  assign capture_s = (state_q == S_CAPTURE);

  // Period sequencing: state transitions plus the RUN and DRAIN counters.
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        state_d = S_TICK;
      end
      S_TICK: begin
        state_d   = S_RUN;
        run_cnt_d = RUN_ZERO;
      end
      S_RUN: begin
        // The counter wraps back to zero on the last enabled clock.
        if (run_cnt_q == RUN_LAST) begin
          run_cnt_d   = RUN_ZERO;
          drain_cnt_d = DRAIN_ZERO;
          state_d     = (CAPTURE_DELAY == 0) ? S_CAPTURE : S_DRAIN;
        end else begin
          run_cnt_d = run_cnt_q + PERIOD_BITS'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = DRAIN_ZERO;
          state_d     = S_CAPTURE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      S_CAPTURE: begin
        if (enable_i) begin
          state_d = S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        run_cnt_d   = RUN_ZERO;
        drain_cnt_d = DRAIN_ZERO;
      end
    endcase
  end

  // Pending resync/apply flags. A request arriving in the servicing cycle
  // itself survives the clear and waits for the next period.
  always_comb begin
    resync_pend_d = 1'b0;
    apply_pend_d  = 1'b0;
    if (state_q == S_PRE) begin
      resync_pend_d = resync_i;
    end else begin
      resync_pend_d = resync_pend_q | resync_i;
    end
    if (state_q == S_TICK) begin
      apply_pend_d = apply_req_i;
    end else if (state_q == S_IDLE) begin
      // Idle requests go down the two-clock direct path instead.
      apply_pend_d = apply_pend_q;
    end else begin
      apply_pend_d = apply_pend_q | apply_req_i;
    end
    idle_apply_d = (state_q == S_IDLE) & apply_req_i;
  end

  // Strobe outputs are computed from the upcoming state so they are
  // registered yet still coincide with the state they belong to.
  always_comb begin
    tick_d  = (state_d == S_TICK);
    ce_d    = (state_d == S_RUN);
    rst_d   = (state_d == S_PRE) & resync_pend_d;
    // The idle path lands two clocks after the request, behind any load
    // strobe issued in the same cycle as the request.
    apply_d = ((state_d == S_TICK) & apply_pend_d) | idle_apply_q;
    busy_d  = (state_d != S_IDLE);
  end

  // Scale/offset staging, accepted in any state.
  always_comb begin
    scale_d     = scale_q;
    offset_d    = offset_q;
    scale_ce_d  = scale_wr_i;
    offset_ce_d = offset_wr_i;
    if (scale_wr_i) begin
      scale_d = scale_i;
    end else begin
      scale_d = scale_q;
    end
    if (offset_wr_i) begin
      offset_d = offset_i;
    end else begin
      offset_d = offset_q;
    end
  end

  // Result capture and valid/ack/overrun handshake. A capture that meets an
  // ack in the same clock keeps valid high without flagging overrun.
  always_comb begin
    sq_d      = sq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (capture_s) begin
      sq_d    = sq_accum_i;
      gt_d    = gt_accum_i;
      lt_d    = lt_accum_i;
      valid_d = 1'b1;
    end else if (ack_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (capture_s & valid_q & ~ack_i) begin
      overrun_d = 1'b1;
    end else if (ack_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

`ifdef AGC_PERIOD_COUNT_EN
  // Capture counter, cleared when a resync is actually issued to the core.
  always_comb begin
    pcount_d = pcount_q;
    if ((state_q == S_PRE) && rst_q) begin
      pcount_d = 16'd0;
    end else if (capture_s) begin
      pcount_d = pcount_q + 16'd1;
    end else begin
      pcount_d = pcount_q;
    end
  end
`endif

  // State, counters, pending flags and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      run_cnt_q     <= RUN_ZERO;
      drain_cnt_q   <= DRAIN_ZERO;
      resync_pend_q <= 1'b0;
      apply_pend_q  <= 1'b0;
      idle_apply_q  <= 1'b0;
      tick_q        <= 1'b0;
      ce_q          <= 1'b0;
      rst_q         <= 1'b0;
      apply_q       <= 1'b0;
      busy_q        <= 1'b0;
      scale_q       <= 17'd0;
      scale_ce_q    <= 1'b0;
      offset_q      <= 16'd0;
      offset_ce_q   <= 1'b0;
      sq_q          <= {SQ_BITS{1'b0}};
      gt_q          <= {PR_BITS{1'b0}};
      lt_q          <= {PR_BITS{1'b0}};
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef AGC_PERIOD_COUNT_EN
      pcount_q      <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      resync_pend_q <= resync_pend_d;
      apply_pend_q  <= apply_pend_d;
      idle_apply_q  <= idle_apply_d;
      tick_q        <= tick_d;
      ce_q          <= ce_d;
      rst_q         <= rst_d;
      apply_q       <= apply_d;
      busy_q        <= busy_d;
      scale_q       <= scale_d;
      scale_ce_q    <= scale_ce_d;
      offset_q      <= offset_d;
      offset_ce_q   <= offset_ce_d;
      sq_q          <= sq_d;
      gt_q          <= gt_d;
      lt_q          <= lt_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
`ifdef AGC_PERIOD_COUNT_EN
      pcount_q      <= pcount_d;
`endif
    end
  end

  assign agc_tick_o      = tick_q;
  assign agc_ce_o        = ce_q;
  assign agc_rst_o       = rst_q;
  assign agc_apply_o     = apply_q;
  assign busy_o          = busy_q;
  assign agc_scale_o     = scale_q;
  assign agc_scale_ce_o  = scale_ce_q;
  assign agc_offset_o    = offset_q;
  assign agc_offset_ce_o = offset_ce_q;
  assign sq_o            = sq_q;
  assign gt_o            = gt_q;
  assign lt_o            = lt_q;
  assign valid_o         = valid_q;
  assign overrun_o       = overrun_q;
`ifdef AGC_PERIOD_COUNT_EN
  assign period_count_o  = pcount_q;
`endif

endmodule

// File: tb/tb_agc_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for agc_sequencer (PERIOD_BITS=4, CAPTURE_DELAY=3, 22-clock period).
// A timeline model predicts strobe cycles and per-cycle status into
// scoreboard queues; a monitor compares the DUT against them on the falling
// edge of the clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_agc_sequencer;
  localparam int PB      = 4;
  localparam int CD      = 3;
  localparam int SQW     = 25;
  localparam int PRW     = 21;
  localparam int RUNLEN  = 1 << PB;
  localparam int CAP_OFF = RUNLEN + CD + 1;   // tick cycle to capture cycle
  localparam int PERIOD  = CAP_OFF + 2;       // tick to next tick

  logic clk = 1'b0;
  logic rst_n_i, enable_i, resync_i, scale_wr_i, offset_wr_i, apply_req_i, ack_i;
  logic [16:0] scale_i;
  logic [15:0] offset_i;
  logic [SQW-1:0] sq_accum_i;
  logic [PRW-1:0] gt_accum_i, lt_accum_i;
  logic agc_tick_o, agc_ce_o, agc_rst_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o;
  logic [16:0] agc_scale_o;
  logic [15:0] agc_offset_o;
  logic [SQW-1:0] sq_o;
  logic [PRW-1:0] gt_o, lt_o;
  logic valid_o, overrun_o, busy_o;

  agc_sequencer #(.PERIOD_BITS(PB), .CAPTURE_DELAY(CD), .SQ_BITS(SQW), .PR_BITS(PRW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .enable_i(enable_i), .resync_i(resync_i),
    .scale_i(scale_i), .scale_wr_i(scale_wr_i), .offset_i(offset_i),
    .offset_wr_i(offset_wr_i), .apply_req_i(apply_req_i),
    .sq_accum_i(sq_accum_i), .gt_accum_i(gt_accum_i), .lt_accum_i(lt_accum_i),
    .agc_tick_o(agc_tick_o), .agc_ce_o(agc_ce_o), .agc_rst_o(agc_rst_o),
    .agc_scale_o(agc_scale_o), .agc_scale_ce_o(agc_scale_ce_o),
    .agc_offset_o(agc_offset_o), .agc_offset_ce_o(agc_offset_ce_o),
    .agc_apply_o(agc_apply_o), .sq_o(sq_o), .gt_o(gt_o), .lt_o(lt_o),
    .valid_o(valid_o), .ack_i(ack_i), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: strobe events (kind, cycle) and per-cycle status snapshots.
  typedef struct { int kind; int cy; } ev_t;
  typedef struct {
    int cy; logic valid; logic over; logic busy;
    logic [SQW-1:0] sq; logic [PRW-1:0] gt; logic [PRW-1:0] lt;
    logic [16:0] scale; logic [15:0] offset;
  } st_t;
  ev_t evq[$];
  st_t st_q[$];
  string ev_name[6] = '{"tick", "ce", "apply", "rst", "scale_ce", "offset_ce"};

  int n_chk = 0;
  int n_fail = 0;

  // Reference timeline model.
  bit m_running, m_rs_pend, m_ap_pend, m_valid, m_over;
  int m_tick;
  logic [SQW-1:0] m_sq;
  logic [PRW-1:0] m_gt, m_lt;
  logic [16:0] m_scale;
  logic [15:0] m_offset;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int k, input int c);
    evq.push_back('{kind: k, cy: c});
  endtask

  task automatic push_status(input int c);
    st_q.push_back('{cy: c, valid: m_valid, over: m_over, busy: m_running,
                     sq: m_sq, gt: m_gt, lt: m_lt, scale: m_scale, offset: m_offset});
  endtask

  // A period whose tick lands on cycle s: tick at s, enable s+1 .. s+2^PB.
  task automatic push_period(input int s);
    push_ev(0, s);
    for (int j = 1; j <= RUNLEN; j++) push_ev(1, s + j);
  endtask

  task automatic model_reset();
    evq.delete();
    st_q.delete();
    m_running = 0; m_rs_pend = 0; m_ap_pend = 0; m_valid = 0; m_over = 0;
    m_tick = 0; m_sq = '0; m_gt = '0; m_lt = '0; m_scale = '0; m_offset = '0;
    push_status(cyc);
  endtask

  task automatic model_cycle();
    int c;
    bit capture;
    c = cyc;
    if (rst_n_i !== 1'b1) begin
      push_status(c + 1);
      return;
    end
    if (m_running && c == m_tick - 1) begin
      if (m_rs_pend) push_ev(3, c);
      m_rs_pend = 0;
    end
    if (m_running && c == m_tick) begin
      if (m_ap_pend) push_ev(2, c);
      m_ap_pend = 0;
    end
    if (resync_i) m_rs_pend = 1;
    if (apply_req_i) begin
      if (m_running) m_ap_pend = 1;
      else push_ev(2, c + 2);
    end
    if (scale_wr_i) begin push_ev(4, c + 1); m_scale = scale_i; end
    if (offset_wr_i) begin push_ev(5, c + 1); m_offset = offset_i; end
    capture = m_running && (c == m_tick + CAP_OFF);
    if (capture) begin
      if (m_valid && !ack_i) m_over = 1;
      else if (ack_i) m_over = 0;
      m_valid = 1; m_sq = sq_accum_i; m_gt = gt_accum_i; m_lt = lt_accum_i;
    end else if (ack_i) begin
      m_valid = 0; m_over = 0;
    end
    if (!m_running) begin
      if (enable_i) begin m_running = 1; m_tick = c + 2; push_period(m_tick); end
    end else if (capture) begin
      if (enable_i) begin m_tick = c + 2; push_period(m_tick); end
      else m_running = 0;
    end
    push_status(c + 1);
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    resync_i = 0; apply_req_i = 0; scale_wr_i = 0; offset_wr_i = 0; ack_i = 0;
  endtask

  task automatic monitor();
    bit expd[6];
    bit seen[6];
    st_t st;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) expd[k] = 1'b0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].cy < cyc) begin
          n_chk++; n_fail++;
          $display("FAIL %s_missed: expected at cycle %0d, unchecked at %0d", ev_name[evq[i].kind], evq[i].cy, cyc);
          evq.delete(i);
        end else if (evq[i].cy == cyc) begin
          expd[evq[i].kind] = 1'b1;
          evq.delete(i);
        end
      end
      seen[0] = agc_tick_o; seen[1] = agc_ce_o; seen[2] = agc_apply_o;
      seen[3] = agc_rst_o; seen[4] = agc_scale_ce_o; seen[5] = agc_offset_ce_o;
      for (int k = 0; k < 6; k++)
        if (expd[k] || seen[k]) check(ev_name[k], 128'(seen[k]), 128'(expd[k]));
      if (st_q.size() > 0 && st_q[0].cy == cyc) begin
        st = st_q.pop_front();
        check("handshake", 128'({valid_o, overrun_o, busy_o}), 128'({st.valid, st.over, st.busy}));
        check("results", 128'({sq_o, gt_o, lt_o}), 128'({st.sq, st.gt, st.lt}));
        check("staged", 128'({agc_scale_o, agc_offset_o}), 128'({st.scale, st.offset}));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 0; enable_i = 0; clr();
    scale_i = '0; offset_i = '0; sq_accum_i = '0; gt_accum_i = '0; lt_accum_i = '0;
    model_reset();
    fork monitor(); join_none
    @(posedge clk); #1;
    repeat (3) step();
    rst_n_i = 1;

    // Idle load plus apply in the same clock.
    scale_i = 17'h1000; scale_wr_i = 1; apply_req_i = 1; step(); clr();
    repeat (4) step();
    offset_i = 16'hBEEF; offset_wr_i = 1; scale_i = 17'h1ABCD; scale_wr_i = 1; step(); clr();
    // Resync while idle with enable low stays pending.
    resync_i = 1; step(); clr();
    repeat (3) step();

    // Back-to-back periods: deferred applies, resync mid-RUN, overrun, ack.
    enable_i = 1; sq_accum_i = 25'h123456; gt_accum_i = 21'h0ABCD; lt_accum_i = 21'h01234;
    for (int i = 0; i < 3 * PERIOD + 4; i++) begin
      clr();
      if (i > 25) begin
        sq_accum_i = 25'($urandom); gt_accum_i = 21'($urandom); lt_accum_i = 21'($urandom);
      end
      if (i == 8) apply_req_i = 1;
      if (i > 10 && i < 30 && m_running && cyc == m_tick) apply_req_i = 1;
      if (i == 40) resync_i = 1;
      if (i > 50 && m_running && cyc == m_tick + CAP_OFF) ack_i = 1;
      if (i == 68) ack_i = 1;
      step();
    end

    // Reset at RUN count 7 with apply and resync pending.
    for (int i = 0; i < 3 * PERIOD; i++) begin
      clr();
      if (m_running && cyc == m_tick + 8) break;
      if (m_running && cyc == m_tick + 3) begin apply_req_i = 1; resync_i = 1; end
      step();
    end
    rst_n_i = 0; enable_i = 0;
    #1;
    check("reset_outputs", 128'({agc_tick_o, agc_ce_o, agc_rst_o, agc_scale_o, agc_scale_ce_o,
          agc_offset_o, agc_offset_ce_o, agc_apply_o, sq_o, gt_o, lt_o, valid_o, overrun_o, busy_o}), 128'(0));
    model_reset();
    step(); step();
    rst_n_i = 1;
    repeat (5) step();
    enable_i = 1;
    repeat (PERIOD + 4) step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 4) enable_i = ~enable_i;
      resync_i    = ($urandom_range(0, 99) < 3);
      apply_req_i = ($urandom_range(0, 99) < 4);
      scale_wr_i  = ($urandom_range(0, 99) < 5);
      offset_wr_i = ($urandom_range(0, 99) < 5);
      ack_i       = ($urandom_range(0, 99) < 8);
      scale_i = 17'($urandom); offset_i = 16'($urandom);
      sq_accum_i = 25'($urandom); gt_accum_i = 21'($urandom); lt_accum_i = 21'($urandom);
      step();
    end

    enable_i = 0; clr();
    repeat (2 * PERIOD + 5) step();
    check("leftover_events", 128'(evq.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
